// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Function : Owns HI/LO; sequences the multi-cycle multiplier and the external
//            iterative divider, stalling EX while a long operation is in flight.
// Revision : 1.0
// ============================================================================
module hilo_muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_flush,
    input  logic        pipe_stall,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_annul,
    output logic        div_enable,
    input  logic        div_ready,
    input  logic [63:0] div_result
);

    localparam int               CNT_W    = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             signed_q;

    logic             w_is_long;
    logic             w_is_signed;
    logic [63:0]      w_ext_a;
    logic [63:0]      w_ext_b;
    logic [63:0]      w_product;

    assign w_is_long   = (op == OP_MULT) || (op == OP_MULTU) ||
                         (op == OP_DIV)  || (op == OP_DIVU);
    assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);

    // Low 64 bits of the extended product give both the signed and unsigned result.
    assign w_ext_a   = {{32{signed_q & a_q[31]}}, a_q};
    assign w_ext_b   = {{32{signed_q & b_q[31]}}, b_q};
    assign w_product = w_ext_a * w_ext_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid && !ex_flush) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state_q  <= S_MUL;
                                cnt_q    <= CNT_ONE;
                                a_q      <= src_a;
                                b_q      <= src_b;
                                signed_q <= w_is_signed;
                            end
                            OP_DIV, OP_DIVU: begin
                                // A zero divisor never starts the divider; HI/LO stay as they are.
                                state_q  <= (src_b == 32'd0) ? S_DONE : S_DIV;
                                a_q      <= src_a;
                                b_q      <= src_b;
                                signed_q <= w_is_signed;
                            end
                            OP_MTHI: hi_q <= src_a;
                            OP_MTLO: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (ex_flush) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        {hi_q, lo_q} <= w_product;
                        state_q      <= S_DONE;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DIV: begin
                    if (ex_flush) begin
                        state_q <= S_IDLE;
                    end else if (div_ready) begin
                        hi_q    <= div_result[63:32];
                        lo_q    <= div_result[31:0];
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ex_flush || !pipe_stall) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall_req  = op_valid && w_is_long && (state_q != S_DONE) && !ex_flush;
    assign div_start  = (state_q == S_DIV) && !ex_flush;
    assign div_annul  = (state_q == S_DIV) && ex_flush;
    assign div_enable = !pipe_stall;
    assign div_signed = signed_q;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// Bench for hilo_muldiv_ctrl: directed and random HI/LO-class ops against a
// behavioural model, with a scoreboard monitor and a variable-latency divider.
module tb_hilo_muldiv_ctrl;

    localparam int MUL_CYCLES = 2;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ex_flush;
    logic        pipe_stall;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_annul;
    logic        div_enable;
    logic        div_ready;
    logic [63:0] div_result;

    hilo_muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .ex_flush   (ex_flush),
        .pipe_stall (pipe_stall),
        .stall_req  (stall_req),
        .hi         (hi),
        .lo         (lo),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_annul  (div_annul),
        .div_enable (div_enable),
        .div_ready  (div_ready),
        .div_result (div_result)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          lat_force = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // {remainder, quotient}; signed division truncates toward zero.
    function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        logic [31:0] q, r;
        if (s) begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          pa, pb;
        longint unsigned ua, ub;
        case (o)
            OP_MULT: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                return pa * pb;
            end
            OP_MULTU: begin
                ua = 64'(a);
                ub = 64'(b);
                return ua * ub;
            end
            OP_DIV:  return (b == 0) ? {m_hi, m_lo} : div_ref(1'b1, a, b);
            OP_DIVU: return (b == 0) ? {m_hi, m_lo} : div_ref(1'b0, a, b);
            OP_MTHI: return {a, m_lo};
            OP_MTLO: return {m_hi, a};
            default: return {m_hi, m_lo};
        endcase
    endfunction

    // Iterative divider stand-in: decides at negedge, drives Ready after the next posedge.
    logic        dv_busy;
    int          dv_cnt;
    logic        dv_nxt;
    logic [63:0] dv_res;
    initial begin
        div_ready  = 1'b0;
        div_result = '0;
        dv_busy    = 1'b0;
        dv_cnt     = 0;
        dv_res     = '0;
        forever begin
            @(negedge clk);
            dv_nxt = 1'b0;
            if (!rst || div_annul || !div_start || div_ready) begin
                dv_busy = 1'b0;
            end else begin
                if (!dv_busy) begin
                    dv_busy = 1'b1;
                    dv_cnt  = (lat_force < 0) ? int'($urandom_range(0, 5)) : lat_force;
                    dv_res  = div_ref(div_signed, div_a, div_b);
                end
                if (dv_cnt == 0) dv_nxt = 1'b1;
                else dv_cnt--;
            end
            @(posedge clk);
            #1;
            div_ready  = dv_nxt;
            div_result = dv_nxt ? dv_res : 64'(0);
        end
    end

    // Scoreboard monitor: an instruction advances when it is presented unstalled
    // and not held; its HI/LO effect is visible one cycle later.
    initial begin
        logic [63:0] e;
        bit          pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL hilo_commit: got=%0h want=no_completion", {hi, lo});
                    end else begin
                        e = exp_q.pop_front();
                        check("hilo_commit", {hi, lo}, e);
                    end
                end
                if (op_valid && !stall_req && !ex_flush && !pipe_stall &&
                    op >= OP_MULT && op <= OP_MTLO) pend = 1'b1;
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the posedge ending the instruction.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] r;
        int          cyc;
        bit          is_long, is_mt, dv;
        is_long = (o >= OP_MULT) && (o <= OP_DIVU);
        is_mt   = (o == OP_MTHI) || (o == OP_MTLO);
        dv      = ((o == OP_DIV) || (o == OP_DIVU)) && (b != 0);
        op_valid   = 1'b1;
        op         = o;
        src_a      = a;
        src_b      = b;
        pipe_stall = (hold > 0);
        if (is_long || is_mt) begin
            r    = ref_model(o, a, b);
            m_hi = r[63:32];
            m_lo = r[31:0];
            exp_q.push_back(r);
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!stall_req) break;
            if (dv && cyc > 0) begin
                check("div_start_held", div_start, 1);
                check("div_signed", div_signed, 64'(o == OP_DIV));
                check("div_a", div_a, a);
                check("div_b", div_b, b);
            end else begin
                check("div_start_quiet", div_start, 0);
            end
            cyc++;
            if (cyc > 300) begin
                total++;
                bad++;
                $display("FAIL stall_timeout: got=stalled want=release op=%0d", o);
                break;
            end
        end
        if (o == OP_MULT || o == OP_MULTU) check("mul_stall_cycles", 64'(cyc), 64'(MUL_CYCLES + 1));
        if ((o == OP_DIV || o == OP_DIVU) && b == 0) check("div0_stall_cycles", 64'(cyc), 1);
        if (!is_long) check("short_no_stall", 64'(cyc), 0);
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            if (i == hold) pipe_stall = 1'b0;
            @(negedge clk);
            check("hold_stall_req", stall_req, 0);
            check("hold_no_start", div_start, 0);
            check("div_enable", div_enable, 64'(i == hold));
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = OP_NONE;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        op_valid   = 1'b0;
        op         = OP_NONE;
        src_a      = '0;
        src_b      = '0;
        ex_flush   = 1'b0;
        pipe_stall = 1'b0;
        m_hi       = '0;
        m_lo       = '0;
        repeat (3) next_cycle();
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_stall_req", stall_req, 0);
        check("reset_div_start", div_start, 0);
        check("reset_div_annul", div_annul, 0);
        check("reset_div_enable", div_enable, 1);
        rst = 1'b1;
        next_cycle();

        // Directed cases with known answers
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 0);
        check("mult_plan", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        check("multu_plan", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_plan", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIVU, 32'd100, 32'd7, 0);
        check("divu_plan", {hi, lo}, 64'h0000_0002_0000_000E);
        run_op(OP_MTHI, 32'h0000_1234, 32'd0, 0);
        run_op(OP_MTLO, 32'h0000_5678, 32'd0, 0);
        run_op(OP_DIVU, 32'd77, 32'd0, 0);
        check("div0_plan", {hi, lo}, 64'h0000_1234_0000_5678);
        run_op(OP_DIV, 32'd1000, 32'd3, 4);
        run_op(OP_MTHI, 32'hAAAA_0000, 32'd0, 0);
        run_op(OP_MTLO, 32'h0000_5555, 32'd0, 0);
        check("mt_plan", {hi, lo}, 64'hAAAA_0000_0000_5555);
        run_op(OP_RSVD, 32'h1111_1111, 32'h2222_2222, 0);
        run_op(OP_NONE, 32'h3333_3333, 32'h4444_4444, 0);

        // Flush of a division three cycles in
        lat_force  = 20;
        op_valid   = 1'b1;
        op         = OP_DIV;
        src_a      = 32'd500;
        src_b      = 32'd5;
        repeat (3) next_cycle();
        ex_flush = 1'b1;
        @(negedge clk);
        check("flush_div_annul", div_annul, 1);
        check("flush_div_start", div_start, 0);
        check("flush_stall_req", stall_req, 0);
        next_cycle();
        ex_flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("after_flush_annul", div_annul, 0);
        check("after_flush_start", div_start, 0);
        check("after_flush_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush coincident with divider Ready
        lat_force = 0;
        next_cycle();
        op_valid = 1'b1;
        op       = OP_DIVU;
        src_a    = 32'd999;
        src_b    = 32'd4;
        repeat (2) next_cycle();
        ex_flush = 1'b1;
        @(negedge clk);
        check("coinc_div_annul", div_annul, 1);
        next_cycle();
        ex_flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("coinc_flush_hilo", {hi, lo}, {m_hi, m_lo});
        lat_force = -1;

        // Flush on the final multiply cycle
        next_cycle();
        op_valid = 1'b1;
        op       = OP_MULTU;
        src_a    = 32'h0001_0000;
        src_b    = 32'h0001_0000;
        repeat (MUL_CYCLES) next_cycle();
        ex_flush = 1'b1;
        next_cycle();
        ex_flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("mul_flush_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush in IDLE suppresses an MTHI write and long-op acceptance
        next_cycle();
        op_valid = 1'b1;
        op       = OP_MTHI;
        src_a    = 32'hDEAD_BEEF;
        ex_flush = 1'b1;
        next_cycle();
        op       = OP_DIV;
        src_b    = 32'd3;
        @(negedge clk);
        check("idle_flush_stall", stall_req, 0);
        next_cycle();
        ex_flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("idle_flush_no_start", div_start, 0);
        check("idle_flush_hilo", {hi, lo}, {m_hi, m_lo});
        next_cycle();

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            int          h;
            o = 3'($urandom_range(1, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 3));
            if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(o, a, b, h);
            repeat ($urandom_range(0, 1)) next_cycle();
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        // Asynchronous reset in the middle of a multiply
        next_cycle();
        run_op(OP_MTHI, 32'hCAFE_0001, 32'd0, 0);
        op_valid = 1'b1;
        op       = OP_MULT;
        src_a    = 32'd12345;
        src_b    = 32'd678;
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_hi", hi, 0);
        check("async_rst_lo", lo, 0);
        op_valid = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        exp_q.delete();
        next_cycle();
        rst = 1'b1;

        // Asynchronous reset drops div_start without a clock edge
        lat_force = 20;
        next_cycle();
        op_valid = 1'b1;
        op       = OP_DIV;
        src_a    = 32'd81;
        src_b    = 32'd9;
        repeat (2) next_cycle();
        check("pre_rst_div_start", div_start, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_div_start", div_start, 0);
        op_valid  = 1'b0;
        lat_force = -1;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        run_op(OP_MTLO, 32'h0BAD_F00D, 32'd0, 0);
        check("post_rst_mtlo", {hi, lo}, 64'h0000_0000_0BAD_F00D);
        repeat (3) @(negedge clk);
        check("final_drained", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
